systolic_mm_engine: RTL and testbench
=====================================

# systolic_mm_engine

Parametrised N×N output-stationary systolic matrix-multiply engine computing C = A·B for an N×K by K×N job, with K selectable at run time up to K_MAX. It has internal input skewing, a start/busy job FSM, ready/valid streaming of operand beats, and a held ready/valid result. It is the generalised successor to the fixed 3×3 array and reuses its packed row-major result layout. A host-side loader sits upstream and a result consumer or writeback sits downstream.

## Interface
- N, 3, array dimension (rows = cols), N ≥ 2
- DATA_W, 8, operand width
- K_MAX, 16, maximum inner dimension per job
- ACC_W, 2*DATA_W+$clog2(K_MAX), accumulator/result element width
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  job request; sampled only in IDLE
- k_len  in  $clog2(K_MAX+1)  inner dimension, latched on accepted start
- in_valid  in  1  operand beat valid
- in_ready  out  1  engine accepts a beat (high only in LOAD)
- a_col  in  N*DATA_W  column k of A; A[i][k] at [i*DATA_W +: DATA_W]
- b_row  in  N*DATA_W  row k of B; B[k][j] at [j*DATA_W +: DATA_W]
- busy  out  1  high in every state except IDLE
- out_valid  out  1  result valid (DONE state)
- out_ready  in  1  consumer accepts result
- c_out  out  N*N*ACC_W  C[i][j] at [(i*N+j)*ACC_W +: ACC_W], row-major

## Operation
- FSM states: IDLE → LOAD → DRAIN → DONE → IDLE.
- IDLE: when start=1, latch k_len, saturating values above K_MAX to K_MAX. Clear all accumulators and the beat counter. If the latched length is 0, go to DRAIN; otherwise go to LOAD. The start input is ignored in every other state.
- LOAD: in_ready=1. Each cycle with in_valid=1 is a beat, and the beat counter increments. A cycle with in_valid=0 injects a zero bubble on both a and b, so it contributes nothing. After the k_len-th beat, go to DRAIN.
- DRAIN: feed zeros for exactly 2N-1 cycles, counted by the drain counter, then go to DONE. in_ready=0.
- DONE: out_valid=1, and c_out holds stable. On out_valid & out_ready, go to IDLE. Accumulators keep their value until the next start.
- Skew: row i of A is delayed i cycles, and column j of B is delayed j cycles, using shift-register stages. The array free-runs every cycle.
- PE(i,j): registers a to the right and b downward, and accumulates acc += a*b into ACC_W bits. Overflow wraps modulo 2^ACC_W.
- c_out is driven directly from the accumulators.
- Reset, including reset mid-job: the state goes to IDLE. All accumulators, skew and PE pipeline registers, and counters are cleared. in_ready=0, busy=0, out_valid=0, c_out=0.

## Timing
- A start accepted at edge t puts the engine in LOAD in cycle t+1, with busy=1.
- The last beat is accepted at edge e. DRAIN occupies cycles e+1 … e+2N-1. out_valid rises in cycle e+2N.
- With no bubbles, job latency from start to out_valid is k_len+2N cycles.
- out_ready may already be high when out_valid rises. In that case DONE lasts 1 cycle and IDLE follows, so back-to-back starts are possible every k_len+2N+1 cycles.
- in_ready is a registered state decode. It does not depend combinationally on in_valid.

## Configuration
- SA_SIGNED_EN defined: operands and accumulators are two's-complement signed. Each product is sign-extended to ACC_W.
- SA_SIGNED_EN undefined: operands and accumulators are unsigned, zero-extended.
- No other behaviour changes.

## Structure
- Package sa_pkg holds:
  - the FSM state enum (IDLE, LOAD, DRAIN, DONE);
  - a localparam function for the default ACC_W;
  - the operand/accumulator type selection under SA_SIGNED_EN.
- Sub-module sa_pe is the single MAC processing element. It has clk, rst and a clear input, a_in/b_in, a_out/b_out and acc. The top level instantiates N×N of them in a generate loop. Skew and FSM logic live in the top level.

## Test plan
- Run N=3, k_len=3 with A=[[1,2,3],[4,5,6],[7,8,9]] and B identical, with no bubbles. Required: C=[[30,36,42],[66,81,96],[102,126,150]] and out_valid in cycle start+9.
- Run the same job with in_valid low for 2 cycles between beats 1 and 2. Required: identical C, and out_valid arrives 2 cycles later.
- Issue k_len=0. Required: all C=0, and out_valid at start+2N.
- Hold out_ready=0 for 5 cycles in DONE. Required: c_out stable, out_valid held, and a start pulse during DONE is ignored. Then set out_ready=1; the engine returns to IDLE next cycle.
- Assert rst for 1 cycle in mid-LOAD. Required: all outputs 0 next cycle. A fresh job then produces a correct C with no residue.
- With SA_SIGNED_EN and DATA_W=8, use A all -1, B all 2 and k_len=4. Required: every C[i][j]=-8. Without SA_SIGNED_EN, the same bits give 255·2·4=2040.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic matrix-multiply engine.
// Build option: define SA_SIGNED_EN for two's-complement operands and
// accumulators; leave it undefined for unsigned, zero-extended arithmetic.
package sa_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sa_state_e;

`ifdef SA_SIGNED_EN
   localparam bit SA_SIGNED = 1'b1;
`else
   localparam bit SA_SIGNED = 1'b0;
`endif

   // Accumulator width that cannot overflow for a full K_MAX job of
   // worst-case operands.
   function automatic int sa_acc_w(input int data_w, input int k_max);
      return 2 * data_w + $clog2(k_max);
   endfunction

endpackage

// File: rtl/sa_pe.sv
// Single multiply-accumulate processing element of the systolic array.
// Operand extension follows SA_SIGNED_EN (via sa_pkg::SA_SIGNED).
module sa_pe
   import sa_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [ACC_W-1:0]  acc
);

   logic [DATA_W-1:0] a_d, a_q, b_d, b_q;
   logic [ACC_W-1:0]  acc_d, acc_q;
   logic [ACC_W-1:0]  a_x, b_x, prod;

   // Extend both operands to ACC_W first; the truncated product is then
   // correct modulo 2^ACC_W for signed and unsigned arithmetic alike.
   always_comb begin
      a_d   = a_in;
      b_d   = b_in;
      a_x   = {{(ACC_W-DATA_W){SA_SIGNED & a_in[DATA_W-1]}}, a_in};
      b_x   = {{(ACC_W-DATA_W){SA_SIGNED & b_in[DATA_W-1]}}, b_in};
      prod  = a_x * b_x;
      acc_d = clear ? '0 : acc_q + prod;
   end

   // Operand pass-through registers and accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
      end
   end

   assign a_out = a_q;
   assign b_out = b_q;
   assign acc   = acc_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// N x N output-stationary systolic engine computing C = A*B for a run-time
// inner dimension k_len <= K_MAX. Signedness selected by SA_SIGNED_EN.
//
// state | meaning
// IDLE  | waiting for start; accumulators hold the previous result
// LOAD  | accepting k_len operand beats (in_ready=1)
// DRAIN | 2N-1 zero cycles flushing the skewed wavefront through the array
// DONE  | result valid on c_out until out_ready
module systolic_mm_engine
   import sa_pkg::*;
#(
   parameter int N      = 3,
   parameter int DATA_W = 8,
   parameter int K_MAX  = 16,
   parameter int ACC_W  = sa_acc_w(DATA_W, K_MAX)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [$clog2(K_MAX+1)-1:0]   k_len,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [N*DATA_W-1:0]          a_col,
   input  logic [N*DATA_W-1:0]          b_row,
   output logic                         busy,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [N*N*ACC_W-1:0]         c_out
);

   localparam int KL_W = $clog2(K_MAX+1);
   localparam int DR_W = $clog2(2*N);
   localparam logic [DR_W-1:0] DRAIN_INIT = DR_W'(2*N-2);
   localparam logic [KL_W-1:0] K_SAT      = KL_W'(K_MAX);

   sa_state_e         state_d, state_q;
   logic [KL_W-1:0]   k_len_d, k_len_q;
   logic [KL_W-1:0]   beat_d, beat_q;
   logic [DR_W-1:0]   drain_d, drain_q;
   logic              in_ready_d, in_ready_q;
   logic              busy_d, busy_q;
   logic              out_valid_d, out_valid_q;
   logic              clear;
   logic              load_beat;
   logic [KL_W-1:0]   k_sat;
   logic [KL_W-1:0]   beat_inc;

   assign load_beat = in_ready_q & in_valid;

   // Job sequencing: next state, counters and registered output decodes.
   always_comb begin
      state_d  = state_q;
      k_len_d  = k_len_q;
      beat_d   = beat_q;
      drain_d  = drain_q;
      clear    = 1'b0;
      k_sat    = (k_len > K_SAT) ? K_SAT : k_len;
      beat_inc = beat_q + KL_W'(1);
      case (state_q)
         IDLE: begin
            if (start) begin
               clear   = 1'b1;
               beat_d  = '0;
               k_len_d = k_sat;
               if (k_sat == '0) begin
                  state_d = DRAIN;
                  drain_d = DRAIN_INIT;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            if (in_valid) begin
               beat_d = beat_inc;
               if (beat_inc == k_len_q) begin
                  state_d = DRAIN;
                  drain_d = DRAIN_INIT;
               end
            end
         end
         DRAIN: begin
            if (drain_q == '0) state_d = DONE;
            else               drain_d = drain_q - DR_W'(1);
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == LOAD);
      busy_d      = (state_d != IDLE);
      out_valid_d = (state_d == DONE);
   end

   // FSM state, counters and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         k_len_q     <= '0;
         beat_q      <= '0;
         drain_q     <= '0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_len_q     <= k_len_d;
         beat_q      <= beat_d;
         drain_q     <= drain_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;

   logic [DATA_W-1:0] a_feed [N];
   logic [DATA_W-1:0] b_feed [N];

   // Input skew: lane i is delayed i cycles; idle or bubble cycles feed zero.
   for (genvar gi = 0; gi < N; gi++) begin : g_skew
      logic [DATA_W-1:0] a_raw, b_raw;
      assign a_raw = load_beat ? a_col[gi*DATA_W +: DATA_W] : '0;
      assign b_raw = load_beat ? b_row[gi*DATA_W +: DATA_W] : '0;
      if (gi == 0) begin : g_nodly
         assign a_feed[gi] = a_raw;
         assign b_feed[gi] = b_raw;
      end else begin : g_dly
         logic [DATA_W-1:0] a_sr_d [gi];
         logic [DATA_W-1:0] a_sr_q [gi];
         logic [DATA_W-1:0] b_sr_d [gi];
         logic [DATA_W-1:0] b_sr_q [gi];
         // Shift-register next values for this lane.
         always_comb begin
            a_sr_d[0] = a_raw;
            b_sr_d[0] = b_raw;
            for (int s = 1; s < gi; s++) begin
               a_sr_d[s] = a_sr_q[s-1];
               b_sr_d[s] = b_sr_q[s-1];
            end
         end
         // Skew stages.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int s = 0; s < gi; s++) begin
                  a_sr_q[s] <= '0;
                  b_sr_q[s] <= '0;
               end
            end else begin
               a_sr_q <= a_sr_d;
               b_sr_q <= b_sr_d;
            end
         end
         assign a_feed[gi] = a_sr_q[gi-1];
         assign b_feed[gi] = b_sr_q[gi-1];
      end
   end

   logic [DATA_W-1:0] a_h [N][N];
   logic [DATA_W-1:0] b_v [N][N];
   logic              unused_edges;

   // PE mesh: a moves right along rows, b moves down along columns.
   for (genvar gr = 0; gr < N; gr++) begin : g_row
      for (genvar gc = 0; gc < N; gc++) begin : g_col
         logic [DATA_W-1:0] a_src, b_src;
         logic [ACC_W-1:0]  acc;
         if (gc == 0) begin : g_aw
            assign a_src = a_feed[gr];
         end else begin : g_ai
            assign a_src = a_h[gr][gc-1];
         end
         if (gr == 0) begin : g_bn
            assign b_src = b_feed[gc];
         end else begin : g_bi
            assign b_src = b_v[gr-1][gc];
         end
         sa_pe #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
         ) u_pe (
            .clk   (clk),
            .rst   (rst),
            .clear (clear),
            .a_in  (a_src),
            .b_in  (b_src),
            .a_out (a_h[gr][gc]),
            .b_out (b_v[gr][gc]),
            .acc   (acc)
         );
         assign c_out[(gr*N+gc)*ACC_W +: ACC_W] = acc;
      end
   end

   // Operands leaving the far edges of the mesh are discarded.
   always_comb begin
      unused_edges = 1'b0;
      for (int e = 0; e < N; e++) begin
         unused_edges = unused_edges ^ (^a_h[e][N-1]) ^ (^b_v[N-1][e]);
      end
   end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed self-checking bench for systolic_mm_engine (N=3, DATA_W=8,
// K_MAX=16). Expected results follow SA_SIGNED_EN when it is defined.
module tb_systolic_mm_engine;

   localparam int N      = 3;
   localparam int DATA_W = 8;
   localparam int K_MAX  = 16;
   localparam int ACC_W  = 20;
   localparam int CW     = N*N*ACC_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [4:0]        k_len = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [N*DATA_W-1:0] a_col = '0;
   logic [N*DATA_W-1:0] b_row = '0;
   logic              busy;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [CW-1:0]     c_out;

   int total = 0;
   int bad   = 0;
   int rel   = 0;
   int ev [9];
   logic [CW-1:0] exp_c;

   always #5 clk = ~clk;

   systolic_mm_engine #(
      .N      (N),
      .DATA_W (DATA_W),
      .K_MAX  (K_MAX),
      .ACC_W  (ACC_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .k_len     (k_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_col     (a_col),
      .b_row     (b_row),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c_out     (c_out)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CW-1:0] pack_c(input int v [9]);
      logic [CW-1:0] r;
      r = '0;
      for (int i = 0; i < 9; i++) r[i*ACC_W +: ACC_W] = ACC_W'(v[i]);
      return r;
   endfunction

   function automatic logic [N*DATA_W-1:0] v3(input int x0, input int x1, input int x2);
      return {8'(x2), 8'(x1), 8'(x0)};
   endfunction

   task automatic start_job(input int k);
      start = 1'b1;
      k_len = 5'(k);
      tick();
      start = 1'b0;
      rel   = 1;
   endtask

   task automatic beat(input logic [N*DATA_W-1:0] a, input logic [N*DATA_W-1:0] b);
      in_valid = 1'b1;
      a_col    = a;
      b_row    = b;
      tick();
      in_valid = 1'b0;
      rel++;
   endtask

   task automatic bubble();
      tick();
      rel++;
   endtask

   // rel counts cycles after the start edge: cycle start+rel.
   task automatic wait_out(input string tag, input int exp_rel);
      while (!out_valid && rel < 200) begin
         tick();
         rel++;
      end
      check(tag, CW'(rel), CW'(exp_rel));
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_in_ready", CW'(in_ready), '0);
      check("rst_busy", CW'(busy), '0);
      check("rst_out_valid", CW'(out_valid), '0);
      check("rst_c_out", c_out, '0);

      // Job 1: A*A, no bubbles, consumer already ready
      ev = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
      exp_c = pack_c(ev);
      out_ready = 1'b1;
      start_job(3);
      check("j1_in_ready", CW'(in_ready), CW'(1));
      check("j1_busy", CW'(busy), CW'(1));
      beat(v3(1, 4, 7), v3(1, 2, 3));
      beat(v3(2, 5, 8), v3(4, 5, 6));
      beat(v3(3, 6, 9), v3(7, 8, 9));
      check("j1_drain_in_ready", CW'(in_ready), '0);
      wait_out("j1_latency", 9);
      check("j1_c", c_out, exp_c);
      tick();
      check("j1_idle_busy", CW'(busy), '0);
      check("j1_idle_out_valid", CW'(out_valid), '0);

      // Job 2: same job with two bubbles, then held in DONE
      out_ready = 1'b0;
      start_job(3);
      beat(v3(1, 4, 7), v3(1, 2, 3));
      bubble();
      bubble();
      beat(v3(2, 5, 8), v3(4, 5, 6));
      beat(v3(3, 6, 9), v3(7, 8, 9));
      wait_out("j2_latency", 11);
      check("j2_c", c_out, exp_c);
      for (int h = 0; h < 5; h++) begin
         if (h == 2) begin
            start = 1'b1;
            k_len = 5'd1;
         end
         tick();
         start = 1'b0;
         check("hold_out_valid", CW'(out_valid), CW'(1));
         check("hold_c", c_out, exp_c);
      end
      out_ready = 1'b1;
      tick();
      check("rel_out_valid", CW'(out_valid), '0);
      check("rel_busy", CW'(busy), '0);
      out_ready = 1'b0;
      tick();
      check("rel_start_ignored", CW'(busy), '0);

      // Job 3: k_len = 0 clears the previous result
      out_ready = 1'b1;
      start_job(0);
      check("k0_in_ready", CW'(in_ready), '0);
      check("k0_busy", CW'(busy), CW'(1));
      wait_out("k0_latency", 6);
      check("k0_c", c_out, '0);
      tick();

      // Job 4: k_len above K_MAX saturates to 16 beats of all-ones
      start_job(31);
      for (int k = 0; k < 16; k++) beat(v3(1, 1, 1), v3(1, 1, 1));
      check("sat_in_ready", CW'(in_ready), '0);
      ev = '{16, 16, 16, 16, 16, 16, 16, 16, 16};
      wait_out("sat_latency", 22);
      check("sat_c", c_out, pack_c(ev));
      tick();

      // Job 5: reset in mid-LOAD, then A*I
      start_job(3);
      beat(v3(9, 9, 9), v3(9, 9, 9));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_in_ready", CW'(in_ready), '0);
      check("mrst_busy", CW'(busy), '0);
      check("mrst_out_valid", CW'(out_valid), '0);
      check("mrst_c", c_out, '0);
      start_job(3);
      beat(v3(1, 4, 7), v3(1, 0, 0));
      beat(v3(2, 5, 8), v3(0, 1, 0));
      beat(v3(3, 6, 9), v3(0, 0, 1));
      ev = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      wait_out("ident_latency", 9);
      check("ident_c", c_out, pack_c(ev));
      tick();

      // Job 6: A all 0xFF, B all 2, k_len = 4
      start_job(4);
      for (int k = 0; k < 4; k++) beat(v3(255, 255, 255), v3(2, 2, 2));
`ifdef SA_SIGNED_EN
      ev = '{-8, -8, -8, -8, -8, -8, -8, -8, -8};
`else
      ev = '{2040, 2040, 2040, 2040, 2040, 2040, 2040, 2040, 2040};
`endif
      wait_out("sgn_latency", 10);
      check("sgn_c", c_out, pack_c(ev));
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
